alu_step_sequencer: RTL and testbench
=====================================

# alu_step_sequencer

Parametrised control-step sequencer that drives the datapath's register-enable, bus-select, memory and ALU control lines for register-register ALU instructions. It replaces hand-sequenced testbench control with hardware: a fetch cycle followed by an opcode-dependent number of execute steps. It adds a memory-ready wait state, two-operand and HI/LO-result instruction classes, and illegal-opcode detection. It sits between the instruction register output and the datapath control inputs.

## Interface
- NUM_REGS, 16, number of general registers; width of the one-hot `Rin`/`Rout` vectors.
- REG_SEL_W, 4, register field width in IR; must satisfy 2**REG_SEL_W == NUM_REGS.
- OPCODE_W, 5, opcode field width; also the width of `alu_op`.
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin an instruction; sampled only in IDLE.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir_in  in  32  datapath IR contents. Fields: opcode [31:32-OPCODE_W], Ra next REG_SEL_W bits, Rb next, Rc next.
- Rin / Rout  out  NUM_REGS  one-hot general-register load / bus-drive enables.
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath control lines.
- alu_op  out  OPCODE_W  ALU operation; equals the opcode during the Zin step, else 0.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse during the final execute step.
- illegal  out  1  one-cycle pulse in T3 when the opcode is unsupported.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are a combinational decode of the state register and `ir_in`. No output is active in IDLE.
- Fetch, common to all classes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. PCin is asserted only in the cycle where mem_ready=1; T1 holds while mem_ready=0.
  - T2: MDRout, IRin.
- Class A, 3-operand (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, alu_op.
  - T5: Zlowout, Rin[Ra], done.
  - Then IDLE.
- Class B, 2-operand (neg 10001, not 10010):
  - T3: Rout[Rb], Zin, alu_op.
  - T4: Zlowout, Rin[Ra], done.
  - Then IDLE.
- Class C, HI/LO result (mul 01111, div 10000):
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], Zin, alu_op.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, done.
  - Then IDLE.
- Any other opcode in T3: illegal pulses, no register or bus enable is asserted, and the state returns to IDLE. done does not pulse.
- Rin and Rout are never multi-hot. A register field equal to NUM_REGS-1 or 0 is valid.

## Timing
- Reset (clear=0) immediately forces state IDLE and all outputs to 0, including mid-instruction and during a T1 wait. Operation resumes on the first rising edge after clear returns to 1.
- start is ignored while busy=1. A start in IDLE moves to T0 on the next edge. Back-to-back instructions have at least one IDLE cycle between them.
- Cycles from T0 to done with mem_ready tied high: class A 6, class B 5, class C 7. Each mem_ready=0 cycle in T1 adds one cycle.
- `ir_in` is read from T3 onward. IR changes only in T2, so it is stable for the whole execute phase.

## Configuration
- SEQ_MULDIV_EN: when defined, class C is implemented as above.
- When not defined, opcodes 01111 and 10000 are treated as illegal, and state T6, HIin, LOin and Zhighout are tied to 0.

## Test plan
- Reset: hold clear=0 with start=1 -> busy=0, all outputs 0. Release clear -> T0 on the next edge.
- add R1,R2,R3: ir_in=0x18918000, mem_ready=1.
  - T3 Rout=0x0004 with Yin.
  - T4 Rout=0x0008 with Zin and alu_op=00011.
  - T5 Rin=0x0002 with Zlowout and done.
  - Total 6 cycles.
- not R1,R3: ir_in=0x90980000.
  - T3 Rout=0x0008 with Zin and alu_op=10010.
  - T4 Rin=0x0002 with done.
  - Total 5 cycles.
- mul R2,R4: ir_in=0x79200000 with SEQ_MULDIV_EN defined -> T5 LOin, T6 HIin with done. Without the macro -> illegal pulse in T3, then IDLE.
- Memory wait: mem_ready low for 3 cycles in T1 -> Read held for 4 cycles, PCin asserted only in the last of them. Add total becomes 9 cycles.
- Opcode 11111 -> illegal pulses in T3, no Rin bit set, done stays 0. clear pulsed low during T4 of an add -> IDLE with all outputs 0.

Source files
------------

// File: rtl/alu_step_sequencer.sv
// Fetch/execute control-step sequencer for register-register ALU instructions; T1 stalls until mem_ready.
// Class C (mul/div with HI/LO result) is built only when SEQ_MULDIV_EN is defined, otherwise it decodes as illegal.
module alu_step_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W  = 5
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir_in,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  state_t state;

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic                 cls_a, cls_b, cls_c;
  logic                 unused_ir_bits;

  assign opcode = ir_in[31 -: OPCODE_W];
  assign ra     = ir_in[31-OPCODE_W -: REG_SEL_W];
  assign rb     = ir_in[31-OPCODE_W-REG_SEL_W -: REG_SEL_W];
  assign rc     = ir_in[31-OPCODE_W-2*REG_SEL_W -: REG_SEL_W];
  assign unused_ir_bits = ^ir_in[31-OPCODE_W-3*REG_SEL_W:0];

  // Class A spans add..shl (00011..01000); class B is neg/not.
  assign cls_a = (opcode >= OPCODE_W'(3)) && (opcode <= OPCODE_W'(8));
  assign cls_b = (opcode == OPCODE_W'(17)) || (opcode == OPCODE_W'(18));
`ifdef SEQ_MULDIV_EN
  assign cls_c = (opcode == OPCODE_W'(15)) || (opcode == OPCODE_W'(16));
`else
  assign cls_c = 1'b0;
`endif

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= T0;
        T0:      state <= T1;
        T1:      if (mem_ready) state <= T2;
        T2:      state <= T3;
        T3:      state <= (cls_a || cls_b || cls_c) ? T4 : IDLE;
        T4:      state <= cls_b ? IDLE : T5;
        T5:      state <= cls_c ? T6 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        // Read/MDRin hold through the wait; the PC only commits on the completing cycle.
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (cls_a) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end else if (cls_b) begin
          Rout   = onehot(rb);
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (cls_c) begin
          Rout = onehot(ra);
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (cls_a) begin
          Rout   = onehot(rc);
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (cls_b) begin
          Zlowout = 1'b1;
          Rin     = onehot(ra);
          done    = 1'b1;
        end else if (cls_c) begin
          Rout   = onehot(rb);
          Zin    = 1'b1;
          alu_op = opcode;
        end
      end
      T5: begin
        if (cls_a) begin
          Zlowout = 1'b1;
          Rin     = onehot(ra);
          done    = 1'b1;
        end
`ifdef SEQ_MULDIV_EN
        else if (cls_c) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
`endif
      end
`ifdef SEQ_MULDIV_EN
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed table-driven bench for alu_step_sequencer plus hand-written reset/clear sequences.
module tb_alu_step_sequencer;

  logic        Clock;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir_in;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  alu_step_sequencer #(.NUM_REGS(16), .REG_SEL_W(4), .OPCODE_W(5)) dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir_in(ir_in),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [53:0] act;
  assign act = {Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op, busy, done, illegal};

  localparam logic [13:0] PCOUT = 14'h2000, PCIN = 14'h1000, INCPC = 14'h0800, MARIN = 14'h0400;
  localparam logic [13:0] READ = 14'h0200, MDRIN = 14'h0100, MDROUT = 14'h0080, IRIN = 14'h0040;
  localparam logic [13:0] YIN = 14'h0020, ZIN = 14'h0010, ZLOW = 14'h0008, ZHIGH = 14'h0004;
  localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001, NONE = 14'h0000;

  function automatic logic [53:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [13:0] c, input logic [4:0] alu,
                                     input logic b, input logic d, input logic il);
    mk = {rin, rout, c, alu, b, d, il};
  endfunction

  typedef struct {
    string       name;
    logic        st;
    logic [31:0] ir;
    logic        mr;
    logic [53:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string n, input logic [53:0] a, input logic [53:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic push(input string n, input logic st, input logic [31:0] ir,
                      input logic mr, input logic [53:0] e);
    vec_t v;
    v.name = n; v.st = st; v.ir = ir; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  // IDLE cycle that launches the instruction, then the shared fetch steps.
  task automatic push_fetch(input string n, input logic [31:0] ir, input int waits, input logic hold);
    push({n, "_idle"}, 1'b1, ir, 1'b1, '0);
    push({n, "_t0"}, hold, ir, 1'b1, mk(16'h0, 16'h0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < waits; i++)
      push({n, "_t1wait"}, hold, ir, 1'b0, mk(16'h0, 16'h0, ZLOW | READ | MDRIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push({n, "_t1"}, hold, ir, 1'b1, mk(16'h0, 16'h0, ZLOW | PCIN | READ | MDRIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push({n, "_t2"}, hold, ir, 1'b1, mk(16'h0, 16'h0, MDROUT | IRIN, 5'd0, 1'b1, 1'b0, 1'b0));
  endtask

  localparam logic [31:0] IR_ADD = 32'h18918000;  // add R1,R2,R3
  localparam logic [31:0] IR_NOT = 32'h90980000;  // not R1,R3
  localparam logic [31:0] IR_SHL = 32'h47F80000;  // shl R15,R15,R0
  localparam logic [31:0] IR_NEG = 32'h88780000;  // neg R0,R15
  localparam logic [31:0] IR_MUL = 32'h79200000;  // mul R2,R4
  localparam logic [31:0] IR_ILL = 32'hF8918000;  // opcode 11111

  initial begin
    clear = 1'b0; start = 1'b1; mem_ready = 1'b1; ir_in = IR_ADD;

    // Reset held with start asserted: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check("reset_hold", act, '0);
    end
    clear = 1'b1;
    #1 check("reset_release_idle", act, '0);
    @(posedge Clock); #1;
    start = 1'b0;
    check("reset_t0", act, mk(16'h0, 16'h0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b1, 1'b0, 1'b0));
    @(posedge Clock); #1;  // T1
    @(posedge Clock); #1;  // T2
    @(posedge Clock); #1;  // T3
    check("pre_clear_t3", act, mk(16'h0, 16'h0004, YIN, 5'd0, 1'b1, 1'b0, 1'b0));
    @(posedge Clock); #1;  // T4
    check("pre_clear_t4", act, mk(16'h0, 16'h0008, ZIN, 5'd3, 1'b1, 1'b0, 1'b0));
    #2 clear = 1'b0;
    #1 check("clear_mid_t4", act, '0);
    @(posedge Clock); #1;
    clear = 1'b1;
    check("clear_still_idle", act, '0);
    @(posedge Clock); #1;
    check("clear_no_resume", act, '0);

    push_fetch("add", IR_ADD, 0, 1'b0);
    push("add_t3", 1'b0, IR_ADD, 1'b1, mk(16'h0, 16'h0004, YIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push("add_t4", 1'b0, IR_ADD, 1'b1, mk(16'h0, 16'h0008, ZIN, 5'd3, 1'b1, 1'b0, 1'b0));
    push("add_t5", 1'b0, IR_ADD, 1'b1, mk(16'h0002, 16'h0, ZLOW, 5'd0, 1'b1, 1'b1, 1'b0));
    push("add_end", 1'b0, IR_ADD, 1'b1, '0);

    // start kept high while busy must not disturb the sequence.
    push_fetch("not", IR_NOT, 0, 1'b1);
    push("not_t3", 1'b1, IR_NOT, 1'b1, mk(16'h0, 16'h0008, ZIN, 5'd18, 1'b1, 1'b0, 1'b0));
    push("not_t4", 1'b1, IR_NOT, 1'b1, mk(16'h0002, 16'h0, ZLOW, 5'd0, 1'b1, 1'b1, 1'b0));
    push("not_end", 1'b0, IR_NOT, 1'b1, '0);

    push_fetch("addwait", IR_ADD, 3, 1'b0);
    push("addwait_t3", 1'b0, IR_ADD, 1'b1, mk(16'h0, 16'h0004, YIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push("addwait_t4", 1'b0, IR_ADD, 1'b1, mk(16'h0, 16'h0008, ZIN, 5'd3, 1'b1, 1'b0, 1'b0));
    push("addwait_t5", 1'b0, IR_ADD, 1'b1, mk(16'h0002, 16'h0, ZLOW, 5'd0, 1'b1, 1'b1, 1'b0));
    push("addwait_end", 1'b0, IR_ADD, 1'b1, '0);

    push_fetch("shl", IR_SHL, 0, 1'b0);
    push("shl_t3", 1'b0, IR_SHL, 1'b1, mk(16'h0, 16'h8000, YIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push("shl_t4", 1'b0, IR_SHL, 1'b1, mk(16'h0, 16'h0001, ZIN, 5'd8, 1'b1, 1'b0, 1'b0));
    push("shl_t5", 1'b0, IR_SHL, 1'b1, mk(16'h8000, 16'h0, ZLOW, 5'd0, 1'b1, 1'b1, 1'b0));
    push("shl_end", 1'b0, IR_SHL, 1'b1, '0);

    push_fetch("neg", IR_NEG, 0, 1'b0);
    push("neg_t3", 1'b0, IR_NEG, 1'b1, mk(16'h0, 16'h8000, ZIN, 5'd17, 1'b1, 1'b0, 1'b0));
    push("neg_t4", 1'b0, IR_NEG, 1'b1, mk(16'h0001, 16'h0, ZLOW, 5'd0, 1'b1, 1'b1, 1'b0));
    push("neg_end", 1'b0, IR_NEG, 1'b1, '0);

    push_fetch("ill", IR_ILL, 0, 1'b0);
    push("ill_t3", 1'b0, IR_ILL, 1'b1, mk(16'h0, 16'h0, NONE, 5'd0, 1'b1, 1'b0, 1'b1));
    push("ill_end", 1'b0, IR_ILL, 1'b1, '0);

    push_fetch("mul", IR_MUL, 0, 1'b0);
`ifdef SEQ_MULDIV_EN
    push("mul_t3", 1'b0, IR_MUL, 1'b1, mk(16'h0, 16'h0004, YIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push("mul_t4", 1'b0, IR_MUL, 1'b1, mk(16'h0, 16'h0010, ZIN, 5'd15, 1'b1, 1'b0, 1'b0));
    push("mul_t5", 1'b0, IR_MUL, 1'b1, mk(16'h0, 16'h0, ZLOW | LOIN, 5'd0, 1'b1, 1'b0, 1'b0));
    push("mul_t6", 1'b0, IR_MUL, 1'b1, mk(16'h0, 16'h0, ZHIGH | HIIN, 5'd0, 1'b1, 1'b1, 1'b0));
`else
    push("mul_t3", 1'b0, IR_MUL, 1'b1, mk(16'h0, 16'h0, NONE, 5'd0, 1'b1, 1'b0, 1'b1));
`endif
    push("mul_end", 1'b0, IR_MUL, 1'b1, '0);

    foreach (vecs[k]) begin
      start     = vecs[k].st;
      ir_in     = vecs[k].ir;
      mem_ready = vecs[k].mr;
      #1 check(vecs[k].name, act, vecs[k].exp);
      @(posedge Clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
